// File: rtl/tube_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tube_scheduler
// Brief    : Paces scrolling tube obstacles, assigns height classes from an
//            LFSR, tracks score and runs the IDLE/RUN/PAUSED/OVER game FSM.
// Revision : 1.0 - initial release
// ============================================================================
module tube_scheduler #(
  parameter int         NUM_TUBES = 4,
  parameter int         TICK_DIV  = 250000,
  parameter int         SCREEN_W  = 850,
  parameter int         SPACING   = 212,
  parameter int         TUBE_W    = 60,
  parameter int         BIRD_X    = 200,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   collide,
  output logic                   tick,
  output logic [10*NUM_TUBES-1:0] tube_h,
  output logic [3*NUM_TUBES-1:0]  tube_state,
  output logic [1:0]             game_state,
  output logic [9:0]             score,
  output logic                   score_pulse
);

  localparam int               c_DIV_W     = $clog2(TICK_DIV);
  localparam int               c_CNT_W     = $clog2(NUM_TUBES + 1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
  localparam logic [9:0]       c_WRAP_H    = 10'(SCREEN_W - 1);
  localparam logic [9:0]       c_PASS_H    = 10'(BIRD_X - TUBE_W);
  localparam logic [9:0]       c_SCORE_MAX = 10'd999;
  localparam logic [7:0]       c_LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_step;
  logic                 w_reload;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [7:0]           r_lfsr;
  logic [7:0]           w_lfsr_nxt;
  logic [NUM_TUBES-1:0] w_pass;
  logic [c_CNT_W-1:0]   w_pass_cnt;
  logic [10:0]          w_score_sum;
  logic [9:0]           w_score_nxt;
  logic [9:0]           r_score;
  logic                 r_tick;
  logic                 r_score_pulse;

  // ---------------------------------------------------------------- game FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A step needs a clean RUN cycle: a collision on the terminal count wins.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_reload    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_step = (r_div_cnt == c_DIV_LAST) && !collide;
        if (collide)    w_state_nxt = ST_OVER;
        else if (pause) w_state_nxt = ST_PAUSED;
      end
      ST_PAUSED: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_OVER: begin
        if (start) begin
          w_state_nxt = ST_IDLE;
          w_reload    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------ move divider
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN:    r_div_cnt <= (collide || w_step) ? '0 : r_div_cnt + 1'b1;
        ST_PAUSED: r_div_cnt <= r_div_cnt;
        default:   r_div_cnt <= '0;
      endcase
    end
  end

  // ------------------------------------------------------------------- LFSR
  // Free-running in every state so wrap heights depend on player timing.
  assign w_lfsr_nxt = {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? c_LFSR_TAPS : 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= w_lfsr_nxt;
    end
  end

  // ------------------------------------------------------------- tube slots
  for (genvar gi = 0; gi < NUM_TUBES; gi++) begin : g_slot
    localparam logic [9:0] c_H_INIT  = 10'(SCREEN_W - 1 - gi * SPACING);
    localparam logic [2:0] c_ST_INIT = {2'(gi % 4), 1'b0};

    logic [9:0] r_h;
    logic [2:0] r_st;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_h  <= c_H_INIT;
        r_st <= c_ST_INIT;
      end else if (w_reload) begin
        r_h  <= c_H_INIT;
        r_st <= c_ST_INIT;
      end else if (w_step) begin
        if (r_h == 10'd0) begin
          r_h  <= c_WRAP_H;
          r_st <= {r_lfsr[(gi + 2) % 8], r_lfsr[(gi + 1) % 8], r_lfsr[gi % 8]};
        end else begin
          r_h  <= r_h - 10'd1;
        end
      end
    end

    assign w_pass[gi]              = (r_h == c_PASS_H);
    assign tube_h[10*gi +: 10]     = r_h;
    assign tube_state[3*gi +: 3]   = r_st;
  end

  // ------------------------------------------------------------------ score
  always_comb begin
    w_pass_cnt = '0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      w_pass_cnt = w_pass_cnt + c_CNT_W'(w_pass[i]);
    end
  end

  assign w_score_sum = {1'b0, r_score} + 11'(w_pass_cnt);
  assign w_score_nxt = (w_score_sum > {1'b0, c_SCORE_MAX}) ? c_SCORE_MAX : w_score_sum[9:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_score       <= '0;
      r_tick        <= 1'b0;
      r_score_pulse <= 1'b0;
    end else begin
      r_tick        <= w_step;
      r_score_pulse <= w_step && (w_pass_cnt != '0) && (r_score != c_SCORE_MAX);
      if (w_reload) begin
        r_score <= '0;
      end else if (w_step) begin
        r_score <= w_score_nxt;
      end
    end
  end

  assign tick        = r_tick;
  assign score       = r_score;
  assign score_pulse = r_score_pulse;
  assign game_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_tube_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tube_scheduler
// Brief    : Two tube_scheduler configurations against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tube_scheduler;
  localparam int NT = 4;

  logic                clk;
  logic                rst;
  logic                start_s   [2];
  logic                pause_s   [2];
  logic                collide_s [2];
  logic                tick_o    [2];
  logic [10*NT-1:0]    th        [2];
  logic [3*NT-1:0]     ts        [2];
  logic [1:0]          gs_o      [2];
  logic [9:0]          sc_o      [2];
  logic                sp_o      [2];
  int                  tests;
  int                  fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int cfg, input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40)
        $display("FAIL cfg%0d %s: got %0d expected %0d at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  function automatic int lfsr_step(input int l);
    return (l >> 1) ^ (((l & 1) != 0) ? 32'hB8 : 32'h0);
  endfunction

  // cfg0: default geometry with a fast divider; cfg1: tiny screen, all slots aligned
  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int TD = (k == 0) ? 4 : 2;
    localparam int SW = (k == 0) ? 850 : 16;
    localparam int SP = (k == 0) ? 212 : 0;
    localparam int TW = 60;
    localparam int BX = (k == 0) ? 200 : 70;

    tube_scheduler #(
      .NUM_TUBES(NT), .TICK_DIV(TD), .SCREEN_W(SW), .SPACING(SP),
      .TUBE_W(TW), .BIRD_X(BX), .LFSR_SEED(8'hA5)
    ) dut (
      .clk(clk), .rst(rst), .start(start_s[k]), .pause(pause_s[k]),
      .collide(collide_s[k]), .tick(tick_o[k]), .tube_h(th[k]),
      .tube_state(ts[k]), .game_state(gs_o[k]), .score(sc_o[k]),
      .score_pulse(sp_o[k])
    );

    int mh [NT];
    int mst [NT];
    int mgs, mdiv, msc, ml;
    int mtick, msp;

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        mgs = 0; mdiv = 0; msc = 0; ml = 'hA5; mtick = 0; msp = 0;
        for (int i = 0; i < NT; i++) begin
          mh[i]  = SW - 1 - i * SP;
          mst[i] = (i % 4) * 2;
        end
      end else begin : m_upd
        bit stp;
        int n;
        int ol;
        stp = (mgs == 1) && (mdiv == TD - 1) && !collide_s[k];
        ol  = ml;
        ml  = lfsr_step(ml);
        mtick = stp ? 1 : 0;
        msp   = 0;
        if (stp) begin
          n = 0;
          for (int i = 0; i < NT; i++) begin
            if (mh[i] == BX - TW) n++;
            if (mh[i] == 0) begin
              mh[i]  = SW - 1;
              mst[i] = ((ol >> ((i + 2) % 8)) & 1) * 4 + ((ol >> ((i + 1) % 8)) & 1) * 2
                       + ((ol >> (i % 8)) & 1);
            end else begin
              mh[i] = mh[i] - 1;
            end
          end
          if (n > 0 && msc < 999) msp = 1;
          msc = (msc + n > 999) ? 999 : msc + n;
        end
        if (mgs == 1)      mdiv = (collide_s[k] || stp) ? 0 : mdiv + 1;
        else if (mgs != 2) mdiv = 0;
        case (mgs)
          0: if (start_s[k]) mgs = 1;
          1: if (collide_s[k]) mgs = 3; else if (pause_s[k]) mgs = 2;
          2: if (start_s[k]) mgs = 1;
          default: if (start_s[k]) begin
            mgs = 0; msc = 0; mdiv = 0;
            for (int i = 0; i < NT; i++) begin
              mh[i]  = SW - 1 - i * SP;
              mst[i] = (i % 4) * 2;
            end
          end
        endcase
      end
    end

    always @(negedge clk) begin
      if (rst === 1'b0) begin
        chk(k, "game_state", gs_o[k], mgs);
        chk(k, "tick", tick_o[k], mtick);
        chk(k, "score", sc_o[k], msc);
        chk(k, "score_pulse", sp_o[k], msp);
        for (int i = 0; i < NT; i++) begin
          chk(k, "tube_h", th[k][10*i +: 10], mh[i]);
          chk(k, "tube_state", ts[k][3*i +: 3], mst[i]);
        end
      end
    end
  end

  task automatic pulse_start(input int k);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
  endtask

  task automatic rand_drive(input int k, input int cycles);
    repeat (cycles) begin
      start_s[k]   = ($urandom_range(0, 7) == 0);
      pause_s[k]   = ($urandom_range(0, 15) == 0);
      collide_s[k] = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    start_s[k] = 1'b0; pause_s[k] = 1'b0; collide_s[k] = 1'b0;
  endtask

  task automatic run_cfg0();
    int ticks;
    int guard;
    int snap;
    int exp3;
    pulse_start(0);
    ticks = 0;
    repeat (8) begin
      @(negedge clk);
      if (tick_o[0]) ticks++;
    end
    chk(0, "ticks_in_8", ticks, 2);
    chk(0, "h_after_2", th[0], {10'd211, 10'd423, 10'd635, 10'd847});

    guard = 0;
    while (!sp_o[0] && guard < 1000) begin @(negedge clk); guard++; end
    chk(0, "pulse_with_tick", tick_o[0], 1);
    chk(0, "first_score", sc_o[0], 1);

    guard = 0;
    while (th[0][39:30] != 10'd0 && guard < 2000) begin @(negedge clk); guard++; end
    chk(0, "slot3_reaches_0", th[0][39:30], 0);
    guard = 0;
    do begin
      snap = g_cfg[0].ml;
      @(negedge clk);
      guard++;
    end while (!tick_o[0] && guard < 10);
    exp3 = ((snap >> 5) & 1) * 4 + ((snap >> 4) & 1) * 2 + ((snap >> 3) & 1);
    chk(0, "wrap_h", th[0], {10'd849, 10'd211, 10'd423, 10'd635});
    chk(0, "wrap_state", ts[0][11:9], exp3);

    repeat (2) @(negedge clk);
    pause_s[0] = 1'b1;
    @(negedge clk);
    pause_s[0] = 1'b0;
    chk(0, "paused", gs_o[0], 2);
    repeat (20) @(negedge clk);
    chk(0, "pause_frozen", th[0], {10'd849, 10'd211, 10'd423, 10'd635});
    pulse_start(0);
    chk(0, "resume_state", gs_o[0], 1);
    chk(0, "resume_no_tick_yet", tick_o[0], 0);
    @(negedge clk);
    chk(0, "resume_tick", tick_o[0], 1);
    chk(0, "resume_h", th[0], {10'd848, 10'd210, 10'd422, 10'd634});

    collide_s[0] = 1'b1;
    @(negedge clk);
    collide_s[0] = 1'b0;
    chk(0, "over", gs_o[0], 3);
    repeat (10) @(negedge clk);
    chk(0, "over_frozen", th[0], {10'd848, 10'd210, 10'd422, 10'd634});
    chk(0, "over_score", sc_o[0], 1);
    pulse_start(0);
    chk(0, "back_idle", gs_o[0], 0);
    chk(0, "reload_h", th[0], {10'd213, 10'd425, 10'd637, 10'd849});
    chk(0, "reload_st", ts[0], {3'd6, 3'd4, 3'd2, 3'd0});
    chk(0, "reload_score", sc_o[0], 0);

    rand_drive(0, 3000);
  endtask

  task automatic run_cfg1();
    int guard;
    int pulses;
    pulse_start(1);
    guard = 0;
    while (!sp_o[1] && guard < 100) begin @(negedge clk); guard++; end
    chk(1, "four_at_once", sc_o[1], 4);
    guard = 0;
    while (sc_o[1] != 10'd999 && guard < 20000) begin @(negedge clk); guard++; end
    chk(1, "reach_999", sc_o[1], 999);
    pulses = 0;
    repeat (200) begin
      @(negedge clk);
      if (sp_o[1]) pulses++;
    end
    chk(1, "no_pulse_at_999", pulses, 0);
    chk(1, "held_999", sc_o[1], 999);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start_s[k] = 1'b0; pause_s[k] = 1'b0; collide_s[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk(0, "reset_state", gs_o[0], 0);
    chk(0, "reset_h", th[0], {10'd213, 10'd425, 10'd637, 10'd849});
    chk(0, "reset_st", ts[0], {3'd6, 3'd4, 3'd2, 3'd0});
    chk(0, "reset_score", sc_o[0], 0);
    chk(0, "reset_tick", tick_o[0], 0);
    chk(1, "reset_h", th[1], {10'd15, 10'd15, 10'd15, 10'd15});

    fork
      run_cfg0();
      run_cfg1();
    join

    // asynchronous reset mid-cycle, away from any clock edge
    pulse_start(0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk(k, "arst_state", gs_o[k], 0);
      chk(k, "arst_tick", tick_o[k], 0);
      chk(k, "arst_pulse", sp_o[k], 0);
      chk(k, "arst_score", sc_o[k], 0);
    end
    chk(0, "arst_h", th[0], {10'd213, 10'd425, 10'd637, 10'd849});
    @(negedge clk);
    rst = 1'b0;

    fork
      rand_drive(0, 1500);
      rand_drive(1, 1500);
    join

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
